elevator_state_reporter: RTL

Reads the registered elevator-controller state (direction, per-floor remaining passengers, per-car boarding counts, per-car floor) and reports it as a framed word stream over a valid/ready interface. It sits downstream of the state registers as their reader and feeds a debug/telemetry sink. On a report request it freezes a snapshot and streams one field per word, followed by an optional checksum word, so the sink sees a consistent view even while the controller keeps running.

---
 rtl/elevator_state_reporter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/elevator_state_reporter.sv
// Snapshots the elevator controller state on request and streams it as a framed
// word sequence (one field per word, optional trailing checksum) over valid/ready.
module elevator_state_reporter #(
    parameter bit INCLUDE_CHECKSUM = 1'b1
) (
    input  logic       clock,
    input  logic       reset_start_n,
    input  logic       report_req,
    input  logic [1:0] dir_elevator,
    input  logic [5:0] remaining_1,
    input  logic [5:0] remaining_2,
    input  logic [5:0] remaining_3,
    input  logic [5:0] remaining_4,
    input  logic [5:0] remaining_5,
    input  logic [5:0] remaining_6,
    input  logic [5:0] remaining_7,
    input  logic [5:0] boarding_1,
    input  logic [5:0] boarding_2,
    input  logic [2:0] curr_elevator_1,
    input  logic [2:0] curr_elevator_2,
    input  logic       rpt_ready,
    output logic       rpt_valid,
    output logic [7:0] rpt_data,
    output logic [3:0] rpt_index,
    output logic       rpt_last,
    output logic       busy,
    output logic       req_overrun,
    output logic       fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = INCLUDE_CHECKSUM ? 4'd12 : 4'd11;

    state_t     state;
    logic [7:0] shadow [12];
    logic [7:0] acc;

    logic       xfer;
    logic [3:0] next_idx;
    logic [7:0] acc_sum;
    logic [7:0] next_word;

    // Handshake: a word moves on a rising edge where rpt_valid & rpt_ready are both 1;
    // otherwise rpt_data/rpt_index/rpt_last hold, and rpt_valid stays up until the last word moves.
    assign xfer     = rpt_valid & rpt_ready;
    assign next_idx = rpt_index + 4'd1;
    assign acc_sum  = acc + rpt_data;
    assign fsm_state = (state == SEND);

    always_comb begin
        next_word = 8'd0;
        case (next_idx)
            4'd0:  next_word = shadow[0];
            4'd1:  next_word = shadow[1];
            4'd2:  next_word = shadow[2];
            4'd3:  next_word = shadow[3];
            4'd4:  next_word = shadow[4];
            4'd5:  next_word = shadow[5];
            4'd6:  next_word = shadow[6];
            4'd7:  next_word = shadow[7];
            4'd8:  next_word = shadow[8];
            4'd9:  next_word = shadow[9];
            4'd10: next_word = shadow[10];
            4'd11: next_word = shadow[11];
            4'd12: next_word = acc_sum;
            default: next_word = 8'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_start_n) begin
        if (!reset_start_n) begin
            state       <= IDLE;
            rpt_valid   <= 1'b0;
            rpt_data    <= 8'd0;
            rpt_index   <= 4'd0;
            rpt_last    <= 1'b0;
            busy        <= 1'b0;
            req_overrun <= 1'b0;
            acc         <= 8'd0;
            for (int i = 0; i < 12; i++) shadow[i] <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (report_req) begin
                        shadow[0]   <= {6'd0, dir_elevator};
                        shadow[1]   <= {2'd0, remaining_1};
                        shadow[2]   <= {2'd0, remaining_2};
                        shadow[3]   <= {2'd0, remaining_3};
                        shadow[4]   <= {2'd0, remaining_4};
                        shadow[5]   <= {2'd0, remaining_5};
                        shadow[6]   <= {2'd0, remaining_6};
                        shadow[7]   <= {2'd0, remaining_7};
                        shadow[8]   <= {2'd0, boarding_1};
                        shadow[9]   <= {2'd0, boarding_2};
                        shadow[10]  <= {5'd0, curr_elevator_1};
                        shadow[11]  <= {5'd0, curr_elevator_2};
                        state       <= SEND;
                        rpt_valid   <= 1'b1;
                        busy        <= 1'b1;
                        rpt_index   <= 4'd0;
                        rpt_data    <= {6'd0, dir_elevator};
                        rpt_last    <= 1'b0;
                        acc         <= 8'd0;
                        req_overrun <= 1'b0;
                    end
                end
                SEND: begin
                    if (report_req) req_overrun <= 1'b1;
                    if (xfer) begin
                        if (rpt_last) begin
                            state     <= IDLE;
                            rpt_valid <= 1'b0;
                            busy      <= 1'b0;
                            rpt_data  <= 8'd0;
                            rpt_index <= 4'd0;
                            rpt_last  <= 1'b0;
                        end else begin
                            // The checksum word itself never reaches here, so acc only sums words 0-11.
                            acc       <= acc_sum;
                            rpt_index <= next_idx;
                            rpt_data  <= next_word;
                            rpt_last  <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
